// File: rtl/poker_pkg.sv
// Shared constants, card encoding helper and dealer FSM state type.
// Imported by card_dealer and lfsr16.
package poker_pkg;

   localparam int DECK_SIZE   = 54;
   localparam int HAND_SIZE   = 17;
   localparam int NUM_PLAYERS = 3;
   localparam int CARD_W      = 8;

   localparam logic [7:0]  BIG_JOKER    = 8'd56;
   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
   localparam logic [15:0] LFSR_MASK    = 16'hB400;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_SHUFFLE,
      ST_DEAL,
      ST_PRESENT,
      ST_WAIT_ACK,
      ST_DONE
   } state_e;

   // Deck index -> card code {rank,suit}; the big joker skips to 56.
   function automatic logic [CARD_W-1:0] card_code(input int n);
      return (n == DECK_SIZE - 1) ? BIG_JOKER : CARD_W'(n);
   endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// lfsr16: 16-bit Galois LFSR random source for the shuffle.
// Ports: clk, rst_n, load_i, seed_i[15:0], en_i, state_o[15:0].
module lfsr16
   import poker_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [15:0] seed_i,
   input  logic        en_i,
   output logic [15:0] state_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         // An all-zero state would lock up the register.
         lfsr_d = (seed_i == 16'h0) ? LFSR_DEFAULT : seed_i;
      end else if (en_i) begin
         lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK)
                            : (lfsr_q >> 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= '0;
      else        lfsr_q <= lfsr_d;
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Shuffles a 54-card deck and deals three 17-card hands plus 3 bottom cards.
// Ports: clk, rst_n, deal_start, deal_abort, seed[15:0], hand_ack ->
//   hand_start, hand_data[135:0], player_id[1:0], bottom_cards[23:0],
//   busy, deal_done. Macro DEALER_SHUFFLE_EN enables the LFSR shuffle;
//   without it the deck is dealt in identity order.
module card_dealer
   import poker_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         deal_start,
   input  logic         deal_abort,
   input  logic [15:0]  seed,
   input  logic         hand_ack,
   output logic         hand_start,
   output logic [135:0] hand_data,
   output logic [1:0]   player_id,
   output logic [23:0]  bottom_cards,
   output logic         busy,
   output logic         deal_done
);

   state_e state_q, state_d;

   logic [CARD_W-1:0] deck_q [DECK_SIZE];
   logic [4:0]        k_q;
   logic [1:0]        player_q;
   logic [1:0]        pid_q;
   logic [135:0]      hand_q;
   logic [23:0]       bottom_q;

   logic [5:0] deal_idx;
   logic       last_card;
   logic       last_player;

   assign deal_idx    = 6'(player_q) * 6'd17 + 6'(k_q);
   assign last_card   = (k_q == 5'(HAND_SIZE - 1));
   assign last_player = (player_q == 2'(NUM_PLAYERS - 1));

`ifdef DEALER_SHUFFLE_EN
   logic [15:0] lfsr_s;
   logic [5:0]  idx_q;
   logic [5:0]  r;
   logic        swap_ok;
   logic        unused_lfsr;

   lfsr16 u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (state_q == ST_IDLE && deal_start && !deal_abort),
      .seed_i  (seed),
      .en_i    (state_q == ST_SHUFFLE),
      .state_o (lfsr_s)
   );

   assign r           = lfsr_s[5:0];
   assign swap_ok     = (r <= idx_q);
   assign unused_lfsr = ^lfsr_s[15:6];
`else
   logic unused_seed;
   assign unused_seed = ^seed;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; abort overrides everything
   always_comb begin
      state_d = state_q;
      if (deal_abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:
               if (deal_start) state_d = ST_INIT;
`ifdef DEALER_SHUFFLE_EN
            ST_INIT:
               state_d = ST_SHUFFLE;
            ST_SHUFFLE:
               if (swap_ok && idx_q == 6'd1) state_d = ST_DEAL;
`else
            ST_INIT:
               state_d = ST_DEAL;
`endif
            ST_DEAL:
               if (last_card) state_d = ST_PRESENT;
            ST_PRESENT:
               state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:
               if (hand_ack) state_d = last_player ? ST_DONE : ST_DEAL;
            ST_DONE:
               state_d = ST_IDLE;
            default:
               state_d = ST_IDLE;
         endcase
      end
   end

   // Deck, counters and held outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DECK_SIZE; i++) deck_q[i] <= '0;
         k_q      <= '0;
         player_q <= '0;
         pid_q    <= '0;
         hand_q   <= '0;
         bottom_q <= '0;
`ifdef DEALER_SHUFFLE_EN
         idx_q    <= '0;
`endif
      end else if (!deal_abort) begin
         unique case (state_q)
            ST_INIT: begin
               for (int i = 0; i < DECK_SIZE; i++) deck_q[i] <= card_code(i);
               k_q      <= '0;
               player_q <= '0;
`ifdef DEALER_SHUFFLE_EN
               idx_q    <= 6'(DECK_SIZE - 1);
`endif
            end
`ifdef DEALER_SHUFFLE_EN
            ST_SHUFFLE: begin
               // Out-of-range draws are retried, keeping the shuffle unbiased.
               if (swap_ok) begin
                  deck_q[idx_q] <= deck_q[r];
                  deck_q[r]     <= deck_q[idx_q];
                  idx_q         <= idx_q - 6'd1;
               end
            end
`endif
            ST_DEAL: begin
               hand_q[{k_q, 3'b000} +: 8] <= deck_q[deal_idx];
               if (last_card) begin
                  k_q   <= '0;
                  pid_q <= player_q;
               end else begin
                  k_q <= k_q + 5'd1;
               end
            end
            ST_WAIT_ACK: begin
               if (hand_ack) begin
                  player_q <= player_q + 2'd1;
                  if (last_player)
                     bottom_q <= {deck_q[DECK_SIZE-1],
                                  deck_q[DECK_SIZE-2],
                                  deck_q[DECK_SIZE-3]};
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      hand_start = (state_q == ST_PRESENT) && !deal_abort;
      deal_done  = (state_q == ST_DONE) && !deal_abort;
      busy       = (state_q != ST_IDLE);
   end

   assign hand_data    = hand_q;
   assign player_id    = pid_q;
   assign bottom_cards = bottom_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a deck-level reference model.
// Build with or without DEALER_SHUFFLE_EN to match the RTL.
module tb_card_dealer;

   localparam int LIMIT = 40000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         deal_start = 1'b0;
   logic         deal_abort = 1'b0;
   logic [15:0]  seed = '0;
   logic         hand_ack = 1'b0;
   logic         hand_start;
   logic [135:0] hand_data;
   logic [1:0]   player_id;
   logic [23:0]  bottom_cards;
   logic         busy;
   logic         deal_done;

   int checks = 0;
   int errors = 0;

   int md [54];

   logic [135:0] g_hand [3];
   logic [1:0]   g_pid [3];
   int           g_lat [3];
   logic         g_extra [3];
   logic [23:0]  g_bot;
   logic         g_done1, g_done2, g_busy1, g_busyend;
   bit           g_to;

   card_dealer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .deal_start   (deal_start),
      .deal_abort   (deal_abort),
      .seed         (seed),
      .hand_ack     (hand_ack),
      .hand_start   (hand_start),
      .hand_data    (hand_data),
      .player_id    (player_id),
      .bottom_cards (bottom_cards),
      .busy         (busy),
      .deal_done    (deal_done)
   );

   always #5 clk = ~clk;

   // Deck after shuffle: identity list, then Fisher-Yates driven by the LFSR
   task automatic model_deck(input logic [15:0] sd);
      for (int n = 0; n < 54; n++) md[n] = (n == 53) ? 56 : n;
`ifdef DEALER_SHUFFLE_EN
      begin
         int i, r, t;
         int s;
         s = (sd == 16'h0) ? 32'hACE1 : int'(sd);
         i = 53;
         while (i >= 1) begin
            r = s % 64;
            s = (s % 2 == 1) ? ((s / 2) ^ 32'hB400) : (s / 2);
            if (r <= i) begin
               t = md[i]; md[i] = md[r]; md[r] = t; i--;
            end
         end
      end
`else
      if (sd == 16'hFFFF) md[0] = md[0];
`endif
   endtask

   function automatic logic [135:0] exp_hand(input int p);
      logic [135:0] e;
      e = '0;
      for (int k = 0; k < 17; k++) e[8*k +: 8] = 8'(md[17*p + k]);
      return e;
   endfunction

   function automatic logic [23:0] exp_bot();
      return {8'(md[53]), 8'(md[52]), 8'(md[51])};
   endfunction

   task automatic wait_hand(inout int cnt);
      while (hand_start !== 1'b1 && cnt < LIMIT) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   // Drives one full deal and records what the DUT produced
   task automatic run_deal(input logic [15:0] sd, input bit noise);
      int cnt;
      g_to = 0;
      @(negedge clk);
      seed = sd;
      deal_start = 1'b1;
      @(negedge clk);
      deal_start = 1'b0;
      cnt = 1;
      for (int p = 0; p < 3; p++) begin
         wait_hand(cnt);
         if (hand_start !== 1'b1) begin
            g_to = 1;
            deal_abort = 1'b1;
            @(negedge clk);
            deal_abort = 1'b0;
            return;
         end
         g_lat[p]  = cnt;
         g_hand[p] = hand_data;
         g_pid[p]  = player_id;
         @(negedge clk);
         g_extra[p] = hand_start;
         repeat ($urandom_range(0, 5)) @(negedge clk);
         hand_ack = 1'b1;
         @(negedge clk);
         hand_ack = 1'b0;
         cnt = 1;
         if (p < 2 && noise) begin
            repeat ($urandom_range(1, 8)) begin
               @(negedge clk);
               cnt++;
            end
            hand_ack = 1'b1;
            @(negedge clk);
            cnt++;
            hand_ack = 1'b0;
         end
      end
      g_done1 = deal_done;
      g_busy1 = busy;
      g_bot   = bottom_cards;
      @(negedge clk);
      g_done2   = deal_done;
      g_busyend = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (hand_start !== 1'b0) begin
         errors++; $display("FAIL reset_hand_start got %b exp 0", hand_start);
      end
      checks++;
      if (hand_data !== '0) begin
         errors++; $display("FAIL reset_hand_data got %h exp 0", hand_data);
      end
      checks++;
      if (player_id !== 2'd0) begin
         errors++; $display("FAIL reset_player_id got %0d exp 0", player_id);
      end
      checks++;
      if (bottom_cards !== 24'h0) begin
         errors++; $display("FAIL reset_bottom got %h exp 0", bottom_cards);
      end
      checks++;
      if (busy !== 1'b0 || deal_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_done got %b%b exp 00", busy, deal_done);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity_deal();
      model_deck(16'h0);
      run_deal(16'h0, 1'b0);
      checks++;
      if (g_to) begin
         errors++; $display("FAIL ident_timeout got timeout exp hand");
         return;
      end
`ifndef DEALER_SHUFFLE_EN
      checks++;
      if (g_lat[0] != 19) begin
         errors++; $display("FAIL ident_latency got %0d exp 19", g_lat[0]);
      end
      checks++;
      if (g_bot !== 24'h383433) begin
         errors++; $display("FAIL ident_bottom_const got %h exp 383433", g_bot);
      end
`endif
      for (int p = 0; p < 3; p++) begin
         checks++;
         if (g_pid[p] !== 2'(p)) begin
            errors++; $display("FAIL ident_pid got %0d exp %0d", g_pid[p], p);
         end
         checks++;
         if (g_hand[p] !== exp_hand(p)) begin
            errors++;
            $display("FAIL ident_hand%0d got %h exp %h", p, g_hand[p], exp_hand(p));
         end
         checks++;
         if (g_extra[p] !== 1'b0) begin
            errors++; $display("FAIL ident_pulse_width got %b exp 0", g_extra[p]);
         end
      end
      for (int p = 1; p < 3; p++) begin
         checks++;
         if (g_lat[p] != 18) begin
            errors++; $display("FAIL ident_next_lat got %0d exp 18", g_lat[p]);
         end
      end
      checks++;
      if (g_bot !== exp_bot()) begin
         errors++; $display("FAIL ident_bottom got %h exp %h", g_bot, exp_bot());
      end
      checks++;
      if ({g_done1, g_done2, g_busy1, g_busyend} !== 4'b1010) begin
         errors++;
         $display("FAIL ident_done got %b%b%b%b exp 1010",
                  g_done1, g_done2, g_busy1, g_busyend);
      end
   endtask

   task automatic test_random_deals();
      int seen [256];
      int bad;
      logic [15:0] sd;
      for (int it = 0; it < 6; it++) begin
         sd = 16'($urandom);
         model_deck(sd);
         run_deal(sd, 1'b1);
         checks++;
         if (g_to) begin
            errors++; $display("FAIL rand_timeout got timeout exp hand seed %h", sd);
            continue;
         end
         for (int i = 0; i < 256; i++) seen[i] = 0;
         for (int p = 0; p < 3; p++) begin
            checks++;
            if (g_hand[p] !== exp_hand(p) || g_pid[p] !== 2'(p)) begin
               errors++;
               $display("FAIL rand_hand%0d seed %h got %h/%0d exp %h/%0d",
                        p, sd, g_hand[p], g_pid[p], exp_hand(p), p);
            end
            for (int k = 0; k < 17; k++) seen[g_hand[p][8*k +: 8]]++;
         end
         for (int k = 0; k < 3; k++) seen[g_bot[8*k +: 8]]++;
         bad = 0;
         for (int c = 0; c < 256; c++)
            if (seen[c] != ((c <= 52 || c == 56) ? 1 : 0)) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL rand_perm got %0d bad codes exp 0", bad);
         end
         checks++;
         if (g_bot !== exp_bot() || g_done1 !== 1'b1 || g_busyend !== 1'b0) begin
            errors++;
            $display("FAIL rand_done got %h %b %b exp %h 1 0",
                     g_bot, g_done1, g_busyend, exp_bot());
         end
      end
   endtask

`ifdef DEALER_SHUFFLE_EN
   task automatic test_seed_repeat();
      logic [135:0] a [3];
      logic [23:0]  ab;
      run_deal(16'h1234, 1'b0);
      for (int p = 0; p < 3; p++) a[p] = g_hand[p];
      ab = g_bot;
      run_deal(16'h1234, 1'b0);
      checks++;
      if (g_to || a[0] !== g_hand[0] || a[1] !== g_hand[1] ||
          a[2] !== g_hand[2] || ab !== g_bot) begin
         errors++; $display("FAIL seed_repeat got %h exp %h", g_hand[0], a[0]);
      end
      run_deal(16'h0, 1'b0);
      for (int p = 0; p < 3; p++) a[p] = g_hand[p];
      ab = g_bot;
      run_deal(16'hACE1, 1'b0);
      checks++;
      if (g_to || a[0] !== g_hand[0] || a[1] !== g_hand[1] ||
          a[2] !== g_hand[2] || ab !== g_bot) begin
         errors++; $display("FAIL seed_zero got %h exp %h", a[0], g_hand[0]);
      end
   endtask
`endif

   task automatic test_ack_stall();
      logic [135:0] h0;
      logic [1:0]   p0;
      bit           stable;
      int           cnt;
      logic [15:0]  sd;
      sd = 16'($urandom);
      model_deck(sd);
      @(negedge clk);
      seed = sd;
      deal_start = 1'b1;
      @(negedge clk);
      deal_start = 1'b0;
      cnt = 1;
      wait_hand(cnt);
      checks++;
      if (hand_start !== 1'b1) begin
         errors++; $display("FAIL stall_timeout got timeout exp hand");
         return;
      end
      h0 = hand_data;
      p0 = player_id;
      checks++;
      if (h0 !== exp_hand(0) || p0 !== 2'd0) begin
         errors++; $display("FAIL stall_first got %h/%0d exp %h/0", h0, p0, exp_hand(0));
      end
      stable = 1;
      repeat (100) begin
         @(negedge clk);
         if (hand_data !== h0 || player_id !== p0 || hand_start !== 1'b0)
            stable = 0;
      end
      checks++;
      if (!stable) begin
         errors++; $display("FAIL stall_stable got change exp constant");
      end
      hand_ack = 1'b1;
      @(negedge clk);
      hand_ack = 1'b0;
      @(negedge clk);
      hand_ack = 1'b1;
      @(negedge clk);
      hand_ack = 1'b0;
      cnt = 3;
      wait_hand(cnt);
      checks++;
      if (hand_start !== 1'b1 || player_id !== 2'd1 || cnt != 18 ||
          hand_data !== exp_hand(1)) begin
         errors++;
         $display("FAIL stall_deal_ack got pid %0d lat %0d exp pid 1 lat 18",
                  player_id, cnt);
      end
      @(negedge clk);
      deal_abort = 1'b1;
      @(negedge clk);
      deal_abort = 1'b0;
   endtask

   task automatic test_abort();
      bit quiet;
      int cnt;
      @(negedge clk);
      seed = 16'($urandom);
      deal_start = 1'b1;
      @(negedge clk);
      deal_start = 1'b0;
      cnt = 1;
      wait_hand(cnt);
      checks++;
      if (hand_start !== 1'b1) begin
         errors++; $display("FAIL abort_timeout got timeout exp hand");
         return;
      end
      @(negedge clk);
      hand_ack = 1'b1;
      @(negedge clk);
      hand_ack = 1'b0;
      repeat (4) @(negedge clk);
      deal_abort = 1'b1;
      @(negedge clk);
      deal_abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || hand_start !== 1'b0 || player_id !== 2'd0) begin
         errors++;
         $display("FAIL abort_deal got busy %b hs %b pid %0d exp 0 0 0",
                  busy, hand_start, player_id);
      end
      quiet = 1;
      repeat (40) begin
         @(negedge clk);
         if (hand_start !== 1'b0 || deal_done !== 1'b0 || busy !== 1'b0)
            quiet = 0;
      end
      checks++;
      if (!quiet) begin
         errors++; $display("FAIL abort_quiet got activity exp none");
      end
      deal_abort = 1'b1;
      deal_start = 1'b1;
      @(negedge clk);
      deal_abort = 1'b0;
      deal_start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL abort_start got busy %b exp 0", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hand_start !== 1'b0) begin
         errors++; $display("FAIL abort_start_late got busy %b exp 0", busy);
      end
   endtask

   task automatic test_reset_mid_deal();
      bit quiet;
      @(negedge clk);
      seed = 16'($urandom);
      deal_start = 1'b1;
      @(negedge clk);
      deal_start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({hand_start, hand_data, player_id, bottom_cards, busy, deal_done}
          !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got %h %h exp 0", hand_data, bottom_cards);
      end
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1;
      repeat (60) begin
         @(negedge clk);
         if (hand_start !== 1'b0 || deal_done !== 1'b0 || busy !== 1'b0)
            quiet = 0;
      end
      checks++;
      if (!quiet) begin
         errors++; $display("FAIL midreset_quiet got activity exp none");
      end
   endtask

   initial begin
      test_reset();
      test_identity_deal();
      test_random_deals();
`ifdef DEALER_SHUFFLE_EN
      test_seed_repeat();
`endif
      test_ack_stall();
      test_abort();
      test_reset_mid_deal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
